// File: rtl/universal_shift_reg.sv
// universal_shift_reg: parametrised universal shift register with hold, parallel
// load, logical/arithmetic shift, rotate and clear, plus a start/busy/done burst
// engine that repeats one shift/rotate operation a programmable number of times.
// Optional feature macro: USR_ROTATE_EN enables ROR/ROL (modes 101/110); when it is
// not defined those codes act as HOLD and a burst with them completes immediately.
module universal_shift_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    input  logic [WIDTH-1:0] par_in,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_r,
    output logic             ser_out_l,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHR  = 3'b010;
    localparam logic [2:0] OP_SHL  = 3'b011;
    localparam logic [2:0] OP_ASR  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_ROL  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       op_r;
    logic [CNT_W-1:0] rem;
    logic [2:0]       op_sel;
    logic [WIDTH-1:0] q_step;
    logic             burst_op;
    logic             burst_go;

    // FSM state register
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: bursts only start from IDLE; DONE always returns to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (en && start) begin
                    state_nxt = burst_go ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (en && (rem == CNT_W'(1))) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: pure decodes of the state register
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            ST_SHIFT: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Burst qualification: only shift/rotate ops with a non-zero count actually run
    always_comb begin
        burst_op = 1'b0;
        case (mode)
            OP_SHR, OP_SHL, OP_ASR: burst_op = 1'b1;
`ifdef USR_ROTATE_EN
            OP_ROR, OP_ROL:         burst_op = 1'b1;
`endif
            default:                burst_op = 1'b0;
        endcase
        burst_go = burst_op && (count != '0);
    end

    // One-step result of the selected operation (latched op during a burst)
    always_comb begin
        op_sel = (state == ST_SHIFT) ? op_r : mode;
        q_step = q;
        case (op_sel)
            OP_HOLD: q_step = q;
            OP_LOAD: q_step = par_in;
            OP_SHR:  q_step = {ser_in_r, q[WIDTH-1:1]};
            OP_SHL:  q_step = {q[WIDTH-2:0], ser_in_l};
            OP_ASR:  q_step = {q[WIDTH-1], q[WIDTH-1:1]};
`ifdef USR_ROTATE_EN
            OP_ROR:  q_step = {q[0], q[WIDTH-1:1]};
            OP_ROL:  q_step = {q[WIDTH-2:0], q[WIDTH-1]};
`endif
            OP_CLR:  q_step = '0;
            default: q_step = q;
        endcase
    end

    // Datapath registers; the start edge only latches the burst, q is untouched
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            q    <= '0;
            op_r <= OP_HOLD;
            rem  <= '0;
        end else if (en) begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_r <= mode;
                        rem  <= count;
                    end else begin
                        q <= q_step;
                    end
                end
                ST_SHIFT: begin
                    q   <= q_step;
                    rem <= rem - CNT_W'(1);
                end
                default: begin
                    q <= q;
                end
            endcase
        end
    end

    // Serial outputs are the bits that leave on right/left moves
    assign ser_out_r = q[0];
    assign ser_out_l = q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Scoreboard bench for universal_shift_reg (WIDTH=8, CNT_W=4). Stimulus is driven
// just after each falling edge and the hand-computed result of the next rising
// edge is queued; a monitor pops and compares one entry at every falling edge.
module tb_universal_shift_reg;

    logic       clk_2;
    logic       reset;
    logic       en;
    logic [2:0] mode;
    logic       ser_in_r;
    logic       ser_in_l;
    logic [7:0] par_in;
    logic       start;
    logic [3:0] count;
    logic [7:0] q;
    logic       ser_out_r;
    logic       ser_out_l;
    logic       busy;
    logic       done;

    typedef struct packed {
        logic [7:0] q;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_fail;
    logic stim_done;

    localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHR = 3'b010, SHL = 3'b011;
    localparam logic [2:0] ASR  = 3'b100, ROR  = 3'b101, ROL = 3'b110, CLR = 3'b111;

    universal_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
        .clk_2     (clk_2),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .ser_in_r  (ser_in_r),
        .ser_in_l  (ser_in_l),
        .par_in    (par_in),
        .start     (start),
        .count     (count),
        .q         (q),
        .ser_out_r (ser_out_r),
        .ser_out_l (ser_out_l),
        .busy      (busy),
        .done      (done)
    );

    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the state expected after the next rising edge
    task automatic cyc(input logic rst, input logic e, input logic [2:0] m,
                       input logic sr, input logic sl, input logic [7:0] p,
                       input logic st, input logic [3:0] c,
                       input logic [7:0] eq, input logic eb, input logic ed);
        exp_t x;
        @(negedge clk_2);
        #1;
        reset    = rst;
        en       = e;
        mode     = m;
        ser_in_r = sr;
        ser_in_l = sl;
        par_in   = p;
        start    = st;
        count    = c;
        x.q      = eq;
        x.busy   = eb;
        x.done   = ed;
        sb.push_back(x);
    endtask

    // Monitor: compare all outputs against the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_2);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("q", q, e.q);
                chk("busy", {7'd0, busy}, {7'd0, e.busy});
                chk("done", {7'd0, done}, {7'd0, e.done});
                chk("ser_out_r", {7'd0, ser_out_r}, {7'd0, e.q[0]});
                chk("ser_out_l", {7'd0, ser_out_l}, {7'd0, e.q[7]});
            end
        end
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        stim_done = 1'b0;
        reset = 1'b1; en = 1'b0; mode = HOLD; ser_in_r = 1'b0; ser_in_l = 1'b0;
        par_in = 8'h00; start = 1'b0; count = 4'd0;

        // reset state
        cyc(1, 0, HOLD, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        // load / shift right / shift left / en=0 hold / clear
        cyc(0, 1, LOAD, 0, 0, 8'h96, 0, 0, 8'h96, 0, 0);
        cyc(0, 1, SHR,  1, 0, 8'h00, 0, 0, 8'hCB, 0, 0);
        cyc(0, 1, SHL,  1, 0, 8'h00, 0, 0, 8'h96, 0, 0);
        cyc(0, 0, LOAD, 0, 0, 8'hFF, 0, 0, 8'h96, 0, 0);
        cyc(0, 1, CLR,  0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        // async reset with q=A5, observed before any rising edge
        cyc(0, 1, LOAD, 0, 0, 8'hA5, 0, 0, 8'hA5, 0, 0);
        @(negedge clk_2);
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_q", q, 8'h00);
        chk("async_rst_busy", {7'd0, busy}, 8'h00);
        chk("async_rst_done", {7'd0, done}, 8'h00);
        sb.push_back('{q: 8'h00, busy: 1'b0, done: 1'b0});
        cyc(0, 1, LOAD, 0, 0, 8'h81, 0, 0, 8'h81, 0, 0);
`ifdef USR_ROTATE_EN
        // ROR burst of 3 with a 2-cycle en=0 pause; start ignored in SHIFT and DONE
        cyc(0, 1, ROR,  0, 0, 8'h00, 1, 3, 8'h81, 1, 0);
        cyc(0, 1, LOAD, 0, 0, 8'h00, 0, 0, 8'hC0, 1, 0);
        cyc(0, 0, LOAD, 0, 0, 8'h00, 0, 0, 8'hC0, 1, 0);
        cyc(0, 0, LOAD, 0, 0, 8'h00, 0, 0, 8'hC0, 1, 0);
        cyc(0, 1, LOAD, 0, 0, 8'h00, 1, 9, 8'h60, 1, 0);
        cyc(0, 1, HOLD, 0, 0, 8'h00, 0, 0, 8'h30, 0, 1);
        cyc(0, 1, ROR,  0, 0, 8'h00, 1, 2, 8'h30, 0, 0);
        cyc(0, 0, HOLD, 0, 0, 8'h00, 0, 0, 8'h30, 0, 0);
        // single-step rotates
        cyc(0, 1, ROR,  0, 0, 8'h00, 0, 0, 8'h18, 0, 0);
        cyc(0, 1, ROL,  0, 0, 8'h00, 0, 0, 8'h30, 0, 0);
`else
        // rotate codes behave as HOLD; rotate burst finishes at once
        cyc(0, 1, ROL,  0, 0, 8'h00, 0, 0, 8'h81, 0, 0);
        cyc(0, 1, ROR,  0, 0, 8'h00, 0, 0, 8'h81, 0, 0);
        cyc(0, 1, ROL,  0, 0, 8'h00, 1, 4, 8'h81, 0, 1);
        cyc(0, 1, HOLD, 0, 0, 8'h00, 0, 0, 8'h81, 0, 0);
`endif
        // ASR burst of 7 from 80, then count=0 and non-shift bursts
        cyc(0, 1, LOAD, 0, 0, 8'h80, 0, 0, 8'h80, 0, 0);
        cyc(0, 1, ASR,  0, 0, 8'h00, 1, 7, 8'h80, 1, 0);
        cyc(0, 1, HOLD, 0, 0, 8'h00, 0, 0, 8'hC0, 1, 0);
        cyc(0, 1, HOLD, 0, 0, 8'h00, 0, 0, 8'hE0, 1, 0);
        cyc(0, 1, HOLD, 0, 0, 8'h00, 0, 0, 8'hF0, 1, 0);
        cyc(0, 1, HOLD, 0, 0, 8'h00, 0, 0, 8'hF8, 1, 0);
        cyc(0, 1, HOLD, 0, 0, 8'h00, 0, 0, 8'hFC, 1, 0);
        cyc(0, 1, HOLD, 0, 0, 8'h00, 0, 0, 8'hFE, 1, 0);
        cyc(0, 1, HOLD, 0, 0, 8'h00, 0, 0, 8'hFF, 0, 1);
        cyc(0, 0, HOLD, 0, 0, 8'h00, 0, 0, 8'hFF, 0, 0);
        cyc(0, 1, ASR,  0, 0, 8'h00, 1, 0, 8'hFF, 0, 1);
        cyc(0, 0, HOLD, 0, 0, 8'h00, 0, 0, 8'hFF, 0, 0);
        cyc(0, 1, LOAD, 0, 0, 8'h11, 1, 5, 8'hFF, 0, 1);
        cyc(0, 1, HOLD, 0, 0, 8'h00, 0, 0, 8'hFF, 0, 0);
        // SHL burst interrupted by reset
        cyc(0, 1, LOAD, 0, 0, 8'h0F, 0, 0, 8'h0F, 0, 0);
        cyc(0, 1, SHL,  0, 1, 8'h00, 1, 5, 8'h0F, 1, 0);
        cyc(0, 1, HOLD, 0, 1, 8'h00, 0, 0, 8'h1F, 1, 0);
        @(negedge clk_2);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_burst_rst_q", q, 8'h00);
        chk("mid_burst_rst_busy", {7'd0, busy}, 8'h00);
        sb.push_back('{q: 8'h00, busy: 1'b0, done: 1'b0});
        cyc(0, 1, HOLD, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0);
        cyc(0, 1, HOLD, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0);
        stim_done = 1'b1;
    end

    // Drain the scoreboard with a bounded wait, then report
    initial begin
        wait (stim_done === 1'b1);
        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(posedge clk_2);
        end
        @(posedge clk_2);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
